// File: rtl/demux1_2_pipe_pkg.sv
// Shared CPU datapath constants: selector polarity and skid-slot state encodings.
package cpu_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slot_state_t;

endpackage

// File: rtl/demux1_2_pipe_if.sv
// Valid/ready bundle for the 1:2 demux: one steered input channel, two output channels.
interface demux1_2_pipe_if #(
  parameter int N = 32
);

  logic [N-1:0] in_data;
  logic         in_ctrl;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a_data;
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] b_data;
  logic         b_valid;
  logic         b_ready;

  modport master (
    output in_data, in_ctrl, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid
  );

  modport slave (
    input  in_data, in_ctrl, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid
  );

endinterface

// File: rtl/demux1_2_pipe_skid_slot2.sv
// Two-entry output buffer, one cycle from push to out_valid when empty.
// full depends only on registered state; out_data/out_valid hold while stalled.
module skid_slot2 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [N-1:0] push_data,
  output logic         full,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready
);
  import cpu_pkg::*;

  slot_state_t  state_q, state_d;
  logic [N-1:0] head_q, head_d;
  logic [N-1:0] tail_q, tail_d;
  logic         pop;

  assign out_valid = (state_q != EMPTY);
  assign full      = (state_q == FULL);
  assign out_data  = head_q;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = ONE;
        end
      end
      ONE: begin
        // Push with pop replaces the head in place, keeping one-per-cycle throughput.
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/demux1_2_pipe.sv
// Registered 1:2 demux steering each input word to A (ctrl=0) or B (ctrl=1), one cycle latency.
// in_ready follows only the selected slot's registered fullness, so a stalled sink never blocks the other.
module demux1_2_pipe #(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  demux1_2_pipe_if.slave  bus
);
  import cpu_pkg::*;

  logic a_full, b_full;
  logic a_push, b_push;
  logic accept;

  assign bus.in_ready = (bus.in_ctrl == SEL_A) ? !a_full : !b_full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign a_push       = accept && (bus.in_ctrl == SEL_A);
  assign b_push       = accept && (bus.in_ctrl == SEL_B);

  skid_slot2 #(.N(N)) u_slot_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (a_push),
    .push_data (bus.in_data),
    .full      (a_full),
    .out_valid (bus.a_valid),
    .out_data  (bus.a_data),
    .out_ready (bus.a_ready)
  );

  skid_slot2 #(.N(N)) u_slot_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (b_push),
    .push_data (bus.in_data),
    .full      (b_full),
    .out_valid (bus.b_valid),
    .out_data  (bus.b_data),
    .out_ready (bus.b_ready)
  );

endmodule

// File: tb/tb_demux1_2_pipe.sv
// Bench for demux1_2_pipe: directed scenarios plus random traffic against per-output queue model.
module tb_demux1_2_pipe;
  import cpu_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux1_2_pipe_if #(.N(N)) bus();

  demux1_2_pipe #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] qa[$];
  logic [N-1:0] qb[$];

  // Model: each output is a FIFO of capacity 2; acceptance only when the chosen FIFO has room.
  function automatic logic model_rdy();
    return (bus.in_ctrl == SEL_A) ? (qa.size() != 2) : (qb.size() != 2);
  endfunction

  task automatic advance();
    logic rdy, va, vb;
    rdy = model_rdy();
    va  = (qa.size() != 0);
    vb  = (qb.size() != 0);
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (va && bus.a_ready) void'(qa.pop_front());
      if (vb && bus.b_ready) void'(qb.pop_front());
      if (bus.in_valid && rdy) begin
        if (bus.in_ctrl == SEL_A) qa.push_back(bus.in_data);
        else                      qb.push_back(bus.in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_ctrl  = SEL_A;
    bus.in_data  = '0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b1;
    bus.b_ready  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      advance();
    end
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: a_valid=%b b_valid=%b want 0 0", bus.a_valid, bus.b_valid);
    end
    n_cmp++;
    if (bus.a_data !== '0 || bus.b_data !== '0) begin
      n_err++;
      $display("FAIL reset_data: a=%h b=%h want 0", bus.a_data, bus.b_data);
    end
    bus.in_ctrl = SEL_B;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rdy_b: got %b want 1", bus.in_ready);
    end
    bus.in_ctrl = SEL_A;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Fill A to two words, then reset between edges.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_00A5;
    @(negedge clk);
    advance();
    bus.in_data = 32'h0000_00A6;
    @(negedge clk);
    advance();
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.a_valid !== 1'b1 || bus.a_data !== 32'h0000_00A5 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL prefill: valid=%b data=%h rdy=%b want 1 000000a5 0", bus.a_valid, bus.a_data, bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.a_valid !== 1'b0 || bus.a_data !== '0) begin
      n_err++;
      $display("FAIL midreset_a: valid=%b data=%h want 0 0", bus.a_valid, bus.a_data);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_rdy_a: got %b want 1", bus.in_ready);
    end
    bus.in_ctrl = SEL_B;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_rdy_b: got %b want 1", bus.in_ready);
    end
    bus.in_ctrl = SEL_A;
    qa.delete();
    qb.delete();
    #1;
    rst_n = 1'b1;
    advance();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_00AA;
    @(negedge clk);
    n_cmp++;
    if (bus.a_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_empty: a_valid=%b want 0", bus.a_valid);
    end
    advance();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.a_valid !== 1'b1 || bus.a_data !== 32'h0000_00AA) begin
      n_err++;
      $display("FAIL post_reset_word: valid=%b data=%h want 1 000000aa", bus.a_valid, bus.a_data);
    end
    drain();
  endtask

  task automatic test_steering();
    bus.a_ready  = 1'b1;
    bus.b_ready  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_ctrl  = SEL_A;
    bus.in_data  = 32'h1111_1111;
    @(negedge clk);
    advance();
    bus.in_ctrl = SEL_B;
    bus.in_data = 32'h2222_2222;
    @(negedge clk);
    n_cmp++;
    if (bus.a_valid !== 1'b1 || bus.a_data !== 32'h1111_1111 || bus.b_valid !== 1'b0) begin
      n_err++;
      $display("FAIL steer_a: a=%b/%h b_valid=%b want 1/11111111 0", bus.a_valid, bus.a_data, bus.b_valid);
    end
    advance();
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b1 || bus.b_data !== 32'h2222_2222) begin
      n_err++;
      $display("FAIL steer_b: a_valid=%b b=%b/%h want 0 1/22222222", bus.a_valid, bus.b_valid, bus.b_data);
    end
    advance();
    @(negedge clk);
    n_cmp++;
    if (bus.b_valid !== 1'b0) begin
      n_err++;
      $display("FAIL steer_b_once: b_valid=%b want 0", bus.b_valid);
    end
    advance();
    drain();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] got[$];
    logic acc;
    bus.a_ready  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_ctrl  = SEL_A;
    bus.in_data  = 32'hA0;
    @(negedge clk);
    advance();
    bus.in_data = 32'hA1;
    @(negedge clk);
    advance();
    bus.in_data = 32'hA2;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_rdy_low: got %b want 0", bus.in_ready);
    end
    advance();
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.a_data !== 32'hA0) begin
      n_err++;
      $display("FAIL bp_hold: rdy=%b data=%h want 0 000000a0", bus.in_ready, bus.a_data);
    end
    bus.a_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.a_valid && bus.a_ready) got.push_back(bus.a_data);
      acc = bus.in_valid && bus.in_ready;
      advance();
      if (acc) bus.in_valid = 1'b0;
    end
    n_cmp++;
    if (got.size() != 3) begin
      n_err++;
      $display("FAIL bp_count: got %0d words want 3", got.size());
    end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_cmp++;
      if (got[i] !== 32'hA0 + i) begin
        n_err++;
        $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 32'hA0 + i);
      end
    end
    drain();
  endtask

  task automatic test_independence();
    logic [N-1:0] got[$];
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_ctrl  = SEL_A;
    bus.in_data  = 32'hC0;
    @(negedge clk);
    advance();
    bus.in_data = 32'hC1;
    @(negedge clk);
    advance();
    bus.in_ctrl = SEL_B;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 32'hB0 + i;
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL indep_rdy[%0d]: got %b want 1", i, bus.in_ready);
      end
      if (bus.b_valid) got.push_back(bus.b_data);
      advance();
    end
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.b_valid) got.push_back(bus.b_data);
      advance();
    end
    n_cmp++;
    if (got.size() != 8) begin
      n_err++;
      $display("FAIL indep_count: got %0d words want 8", got.size());
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      n_cmp++;
      if (got[i] !== 32'hB0 + i) begin
        n_err++;
        $display("FAIL indep_order[%0d]: got %h want %h", i, got[i], 32'hB0 + i);
      end
    end
    n_cmp++;
    if (bus.a_valid !== 1'b1 || bus.a_data !== 32'hC0) begin
      n_err++;
      $display("FAIL indep_a_held: valid=%b data=%h want 1 000000c0", bus.a_valid, bus.a_data);
    end
    drain();
  endtask

  task automatic test_push_pop();
    bus.a_ready  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_ctrl  = SEL_A;
    bus.in_data  = 32'h5;
    @(negedge clk);
    advance();
    bus.in_data = 32'h6;
    bus.a_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.a_data !== 32'h5 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL pp_before: data=%h rdy=%b want 00000005 1", bus.a_data, bus.in_ready);
    end
    advance();
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.a_valid !== 1'b1 || bus.a_data !== 32'h6 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL pp_after: valid=%b data=%h rdy=%b want 1 00000006 1", bus.a_valid, bus.a_data, bus.in_ready);
    end
    bus.a_ready = 1'b1;
    advance();
    @(negedge clk);
    n_cmp++;
    if (bus.a_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pp_one: valid=%b want 0 after single pop", bus.a_valid);
    end
    advance();
    drain();
  endtask

  task automatic test_random();
    logic         pending = 1'b0;
    logic         pva = 1'b0, pvb = 1'b0, par = 1'b0, pbr = 1'b0;
    logic [N-1:0] pa = '0, pb = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!pending) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_ctrl  = $urandom_range(0, 1);
        bus.in_data  = $urandom;
      end
      bus.a_ready = (c % 2000 < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.b_ready = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      n_cmp++;
      if (bus.a_valid !== (qa.size() != 0)) begin
        n_err++;
        $display("FAIL rnd_a_valid c=%0d: got %b want %b", c, bus.a_valid, qa.size() != 0);
      end
      if (qa.size() != 0) begin
        n_cmp++;
        if (bus.a_data !== qa[0]) begin
          n_err++;
          $display("FAIL rnd_a_data c=%0d: got %h want %h", c, bus.a_data, qa[0]);
        end
      end
      n_cmp++;
      if (bus.b_valid !== (qb.size() != 0)) begin
        n_err++;
        $display("FAIL rnd_b_valid c=%0d: got %b want %b", c, bus.b_valid, qb.size() != 0);
      end
      if (qb.size() != 0) begin
        n_cmp++;
        if (bus.b_data !== qb[0]) begin
          n_err++;
          $display("FAIL rnd_b_data c=%0d: got %h want %h", c, bus.b_data, qb[0]);
        end
      end
      n_cmp++;
      if (bus.in_ready !== model_rdy()) begin
        n_err++;
        $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, bus.in_ready, model_rdy());
      end
      if (pva && !par) begin
        n_cmp++;
        if (bus.a_valid !== 1'b1 || bus.a_data !== pa) begin
          n_err++;
          $display("FAIL rnd_a_stable c=%0d: got %b/%h want 1/%h", c, bus.a_valid, bus.a_data, pa);
        end
      end
      if (pvb && !pbr) begin
        n_cmp++;
        if (bus.b_valid !== 1'b1 || bus.b_data !== pb) begin
          n_err++;
          $display("FAIL rnd_b_stable c=%0d: got %b/%h want 1/%h", c, bus.b_valid, bus.b_data, pb);
        end
      end
      pva = bus.a_valid; pa = bus.a_data; par = bus.a_ready;
      pvb = bus.b_valid; pb = bus.b_data; pbr = bus.b_ready;
      pending = bus.in_valid && !model_rdy();
      advance();
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_steering();
    test_backpressure();
    test_independence();
    test_push_pop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux1_2_pipe.md
Name: demux1_2_pipe

Overview:
- Registered 1-to-2 demultiplexer. It is the fan-out counterpart of the datapath 2:1 selectors.
- Each word on a single valid/ready input channel is steered to output A (in_ctrl=0) or output B (in_ctrl=1).
- Each output has a 2-entry skid buffer, so a stalled sink never blocks the other sink.
- Used in the multi-cycle CPU to route a producer, for example the memory data path, to either the register write-back port or the IR/MDR load path.

Parameters:
N, 32, data width of the input and both outputs.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
in_data  input  N  input word.
in_ctrl  input  1  destination select: 0 = output A, 1 = output B. Same sense as the 2:1 selectors.
in_valid  input  1  in_data/in_ctrl are valid.
in_ready  output  1  the selected output's buffer can accept a word this cycle.
a_data  output  N  head word of buffer A.
a_valid  output  1  buffer A is non-empty.
a_ready  input  1  sink A consumes the head this cycle.
b_data  output  N  head word of buffer B.
b_valid  output  1  buffer B is non-empty.
b_ready  input  1  sink B consumes the head this cycle.

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous and active-low.
- Reset: while rst_n=0, both buffer counts are 0 and a_valid=b_valid=0. a_data=b_data={N{1'b0}}. in_ready is high, since it is derived from the zero counts. Assertion mid-operation discards all buffered words immediately, without waiting for a clock edge. On deassertion the block starts empty.
- Each output slot holds a count in {0,1,2}, states EMPTY/ONE/FULL, and storage head/tail. out_valid = (count!=0). out_data = head.
- in_ready:
  - in_ctrl=0: in_ready = (count_A != 2).
  - in_ctrl=1: in_ready = (count_B != 2).
  - in_ready depends only on registered counts and in_ctrl. There is no combinational path from a_ready or b_ready to in_ready.
- push: fires on the selected slot when in_valid & in_ready. The unselected slot never sees a push.
- pop: fires on a slot when out_valid & out_ready. Pops are independent per slot and may coincide with a push to either slot.
- Slot transitions:
  - EMPTY, push: head<=in_data, goes to ONE.
  - ONE, push only: tail<=in_data, goes to FULL.
  - ONE, pop only: goes to EMPTY.
  - ONE, push+pop: head<=in_data, stays ONE.
  - FULL, pop: head<=tail, goes to ONE.
  - FULL, push: cannot happen, because in_ready=0.
- Latency: a word accepted at edge k appears on out_data with out_valid=1 after edge k. That is one cycle of latency when the slot was empty.
- Throughput: one word per cycle into a slot whose sink holds ready=1 continuously.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Ordering: words routed to the same output leave in acceptance order. No ordering is defined between A and B.
- Flow control: in_valid=1 with in_ready=0 accepts nothing. The producer holds its word, and no data is lost or duplicated.
- The block never drops, reorders or duplicates words. out_ready is ignored when out_valid=0.

Decomposition:
- Shared package cpu_pkg, holding:
  - constants SEL_A=1'b0 and SEL_B=1'b1 for in_ctrl;
  - slot state encodings EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- One sub-module, skid_slot2, instantiated twice in demux1_2_pipe.
  - Parameter N. Ports: clk, rst_n, push, push_data, full, out_valid, out_data, out_ready.
  - Contains the count FSM and head/tail registers.
- The top level generates the push enables and the in_ready mux.

Test Plan:
- Reset mid-stream: fill A with 2 words, assert rst_n=0 between edges -> a_valid=0 and a_data=0 immediately; in_ready=1 for either in_ctrl; after deassertion the first word 0x0000_00AA to A appears on a_data one edge after acceptance.
- Steering: send 0x11111111 (ctrl=0), then 0x22222222 (ctrl=1), with a_ready=b_ready=1 -> a_data=0x11111111 valid for exactly one cycle; b_data=0x22222222 valid the following cycle; no cross-delivery.
- Full back-pressure: a_ready=0; push 0xA0, 0xA1, then offer 0xA2 to A -> in_ready=0 while 0xA2 is offered; raise a_ready -> A emits 0xA0, 0xA1, 0xA2 in order, each exactly once.
- Independence: a_ready=0 with A full; stream 0xB0 to 0xB7 to B with b_ready=1 -> all eight accepted back-to-back, in_ready=1 every cycle for in_ctrl=1, B output order 0xB0 to 0xB7.
- Simultaneous push+pop at ONE: A holds 0x5; same cycle push 0x6 with a_ready=1 -> next cycle a_data=0x6, a_valid=1, count stays ONE.
- Random stress: 10k cycles of random valid, ctrl, a_ready and b_ready against scoreboard queues -> zero mismatches; a_data/b_data stable whenever valid=1 and ready=0.
